// File: rtl/mem_pkg.sv
// Shared types and constants for the MEM stage and its SRAM controller.
// The SRAM is 16 bits wide, so each 32-bit word takes a LOW half-access and then a HIGH one.
package mem_pkg;

    localparam int BASE_ADDR   = 1024;
    localparam int SRAM_ADDR_W = 18;
    localparam int SRAM_DATA_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2,
        ST_DONE = 2'd3
    } mem_state_e;

    // The data segment starts at BASE_ADDR. Each 32-bit word maps to one pair of SRAM halves.
    function automatic logic [SRAM_ADDR_W-2:0] word_index(input logic [31:0] byte_addr);
        return (SRAM_ADDR_W-1)'((byte_addr - 32'(BASE_ADDR)) >> 2);
    endfunction

endpackage

// File: rtl/mem_stage_sram_if.sv
// Pin bundle of the external 16-bit asynchronous SRAM.
// The master side drives the address, the write data and the strobes. The slave side returns the read data.
interface mem_stage_sram_if;
    import mem_pkg::*;

    logic [SRAM_ADDR_W-1:0] sram_addr;
    logic [SRAM_DATA_W-1:0] sram_dq_out;
    logic                   sram_dq_oe;
    logic                   sram_we_n;
    logic [SRAM_DATA_W-1:0] sram_dq_in;

    modport master (
        output sram_addr,
        output sram_dq_out,
        output sram_dq_oe,
        output sram_we_n,
        input  sram_dq_in
    );

    modport slave (
        input  sram_addr,
        input  sram_dq_out,
        input  sram_dq_oe,
        input  sram_we_n,
        output sram_dq_in
    );

endinterface

// File: rtl/sram_controller.sv
// Sequences one 32-bit access as two 16-bit SRAM half-accesses (LOW, then HIGH).
// It also produces the ready/freeze handshake that the MEM/WB register uses.
module sram_controller
    import mem_pkg::*;
#(
    parameter int WAIT_CYCLES = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                mem_r_en,
    input  logic                mem_w_en,
    input  logic [31:0]         alu_res,
    input  logic [31:0]         val_rm,
    mem_stage_sram_if.master    sram,
    output logic                ready,
    output logic                freeze,
    output logic                done,
    output logic [31:0]         rdbuf
);

    localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES);

    mem_state_e             state_reg, state_next;
    logic [3:0]             cnt_reg, cnt_next;
    logic [31:0]            rdbuf_reg, rdbuf_next;
    logic                   mem_en;
    logic                   is_read;
    logic                   is_write;
    logic                   phase_end;
    logic                   in_phase;
    logic                   hi_phase;
    logic [SRAM_ADDR_W-2:0] word_idx;

    // When the read and write bits are both set, the read wins.
    assign mem_en    = mem_r_en | mem_w_en;
    assign is_read   = mem_r_en;
    assign is_write  = mem_w_en & ~mem_r_en;
    assign phase_end = (cnt_reg == LAST_CNT);
    assign in_phase  = (state_reg == ST_LOW) || (state_reg == ST_HIGH);
    assign hi_phase  = (state_reg == ST_HIGH);
    assign word_idx  = word_index(alu_res);

    always_comb begin
        state_next = state_reg;
        cnt_next   = 4'd0;
        rdbuf_next = rdbuf_reg;
        case (state_reg)
            ST_IDLE: begin
                if (mem_en) begin
                    state_next = ST_LOW;
                end
            end
            ST_LOW: begin
                if (phase_end) begin
                    state_next = ST_HIGH;
                    if (is_read) begin
                        rdbuf_next[15:0] = sram.sram_dq_in;
                    end
                end else begin
                    cnt_next = cnt_reg + 4'd1;
                end
            end
            ST_HIGH: begin
                if (phase_end) begin
                    state_next = ST_DONE;
                    if (is_read) begin
                        rdbuf_next[31:16] = sram.sram_dq_in;
                    end
                end else begin
                    cnt_next = cnt_reg + 4'd1;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= 4'd0;
            rdbuf_reg <= 32'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            rdbuf_reg <= rdbuf_next;
        end
    end

    // The pins are decoded from state alone. A reset that forces IDLE therefore drops the write strobe at once.
    assign sram.sram_addr   = in_phase ? {word_idx, hi_phase} : '0;
    assign sram.sram_dq_out = (in_phase && is_write) ? (hi_phase ? val_rm[31:16] : val_rm[15:0]) : '0;
    assign sram.sram_dq_oe  = in_phase && is_write;
    assign sram.sram_we_n   = ~(in_phase && is_write);

    assign ready  = (state_reg == ST_IDLE) || (state_reg == ST_DONE);
    // A new command arriving in IDLE stalls upstream at once. Only DONE releases the stall.
    assign freeze = mem_en && (!ready || (state_reg == ST_IDLE));
    assign done   = (state_reg == ST_DONE);
    assign rdbuf  = rdbuf_reg;

endmodule

// File: rtl/mem_stage_sram.sv
// MEM pipeline stage: MEM/WB register plus hazard-unit pass-through.
// SRAM sequencing is handled by sram_controller.
module mem_stage_sram #(
    parameter int WAIT_CYCLES = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wb_en_in,
    input  logic                mem_r_en_in,
    input  logic                mem_w_en_in,
    input  logic [31:0]         alu_res_in,
    input  logic [31:0]         val_Rm_in,
    input  logic [3:0]          dest_in,
    output logic                freeze,
    output logic                wb_en_hazard_out,
    output logic                mem_r_en_hazard_out,
    output logic [3:0]          dest_hazard_out,
    mem_stage_sram_if.master    sram,
    output logic                wb_en_out,
    output logic                mem_r_en_out,
    output logic [31:0]         alu_res_out,
    output logic [31:0]         mem_data_out,
    output logic [3:0]          dest_out
);

    logic        ready;
    logic        done;
    logic [31:0] rdbuf;
    logic        mwb_load;

    sram_controller #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_ctrl (
        .clk      (clk),
        .rst      (rst),
        .mem_r_en (mem_r_en_in),
        .mem_w_en (mem_w_en_in),
        .alu_res  (alu_res_in),
        .val_rm   (val_Rm_in),
        .sram     (sram),
        .ready    (ready),
        .freeze   (freeze),
        .done     (done),
        .rdbuf    (rdbuf)
    );

    assign wb_en_hazard_out    = wb_en_in;
    assign mem_r_en_hazard_out = mem_r_en_in;
    assign dest_hazard_out     = dest_in;

    // The IDLE cycle that accepts a command is stalled even though the controller reports ready.
    // That cycle must also load a bubble.
    assign mwb_load = ready && !freeze;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_en_out    <= 1'b0;
            mem_r_en_out <= 1'b0;
            alu_res_out  <= 32'd0;
            mem_data_out <= 32'd0;
            dest_out     <= 4'd0;
        end else begin
            if (mwb_load) begin
                wb_en_out    <= wb_en_in;
                mem_r_en_out <= mem_r_en_in;
                alu_res_out  <= alu_res_in;
                dest_out     <= dest_in;
            end else begin
                wb_en_out    <= 1'b0;
                mem_r_en_out <= 1'b0;
            end
            if (done) begin
                mem_data_out <= rdbuf;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_sram.sv
// Directed bench for mem_stage_sram: an instance with WAIT_CYCLES=1 and an instance with WAIT_CYCLES=0.
// Both share a small SRAM model.
module tb_mem_stage_sram;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wb_en = 1'b0;
    logic [31:0] alu = 32'd0;
    logic [31:0] val = 32'd0;
    logic [3:0]  dest = 4'd0;
    logic        a_r = 1'b0, a_w = 1'b0;
    logic        z_r = 1'b0, z_w = 1'b0;

    logic        a_freeze, a_wb_hz, a_r_hz, a_wb_out, a_r_out;
    logic [3:0]  a_dest_hz, a_dest_out;
    logic [31:0] a_alu_out, a_data_out;
    logic        z_freeze, z_wb_hz, z_r_hz, z_wb_out, z_r_out;
    logic [3:0]  z_dest_hz, z_dest_out;
    logic [31:0] z_alu_out, z_data_out;

    logic [15:0] sram_mem [0:15];
    logic [17:0] addr_log [0:7];
    logic [15:0] dq_log   [0:7];
    logic        oe_log   [0:7];
    logic        wbo_log  [0:7];

    int vec_cnt = 0;
    int err_cnt = 0;
    int fz, wl;

    mem_stage_sram_if a_bus ();
    mem_stage_sram_if z_bus ();

    always #5 clk = ~clk;

    assign a_bus.sram_dq_in = sram_mem[a_bus.sram_addr[3:0]];
    assign z_bus.sram_dq_in = sram_mem[z_bus.sram_addr[3:0]];

    always @(posedge clk) begin
        if (!rst) begin
            sram_mem[2] <= 16'h00C3;
            sram_mem[3] <= 16'h00A5;
            sram_mem[4] <= 16'hBEEF;
            sram_mem[5] <= 16'hDEAD;
            sram_mem[6] <= 16'h1111;
            sram_mem[7] <= 16'h2222;
        end else begin
            if (!a_bus.sram_we_n) sram_mem[a_bus.sram_addr[3:0]] <= a_bus.sram_dq_out;
            if (!z_bus.sram_we_n) sram_mem[z_bus.sram_addr[3:0]] <= z_bus.sram_dq_out;
        end
    end

    mem_stage_sram #(.WAIT_CYCLES(1)) dut_w1 (
        .clk (clk), .rst (rst),
        .wb_en_in (wb_en), .mem_r_en_in (a_r), .mem_w_en_in (a_w),
        .alu_res_in (alu), .val_Rm_in (val), .dest_in (dest),
        .freeze (a_freeze),
        .wb_en_hazard_out (a_wb_hz), .mem_r_en_hazard_out (a_r_hz), .dest_hazard_out (a_dest_hz),
        .sram (a_bus),
        .wb_en_out (a_wb_out), .mem_r_en_out (a_r_out), .alu_res_out (a_alu_out),
        .mem_data_out (a_data_out), .dest_out (a_dest_out)
    );

    mem_stage_sram #(.WAIT_CYCLES(0)) dut_w0 (
        .clk (clk), .rst (rst),
        .wb_en_in (wb_en), .mem_r_en_in (z_r), .mem_w_en_in (z_w),
        .alu_res_in (alu), .val_Rm_in (val), .dest_in (dest),
        .freeze (z_freeze),
        .wb_en_hazard_out (z_wb_hz), .mem_r_en_hazard_out (z_r_hz), .dest_hazard_out (z_dest_hz),
        .sram (z_bus),
        .wb_en_out (z_wb_out), .mem_r_en_out (z_r_out), .alu_res_out (z_alu_out),
        .mem_data_out (z_data_out), .dest_out (z_dest_out)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_in(input bit sel_z, input logic wb, input logic r, input logic w,
                          input logic [31:0] a, input logic [31:0] v, input logic [3:0] d);
        wb_en = wb; alu = a; val = v; dest = d;
        a_r = sel_z ? 1'b0 : r;
        a_w = sel_z ? 1'b0 : w;
        z_r = sel_z ? r : 1'b0;
        z_w = sel_z ? w : 1'b0;
    endtask

    // Holds the current inputs until freeze drops, steps the loading edge, and logs the first cycles.
    task automatic run_cmd(input string name, input bit sel_z, output int n_fz, output int n_wl);
        bit fin;
        logic f, wen;
        fin = 1'b0; n_fz = 0; n_wl = 0;
        for (int c = 0; c < 40; c++) begin
            #1;
            f   = sel_z ? z_freeze : a_freeze;
            wen = sel_z ? z_bus.sram_we_n : a_bus.sram_we_n;
            if (c < 8) begin
                addr_log[c] = sel_z ? z_bus.sram_addr   : a_bus.sram_addr;
                dq_log[c]   = sel_z ? z_bus.sram_dq_out : a_bus.sram_dq_out;
                oe_log[c]   = sel_z ? z_bus.sram_dq_oe  : a_bus.sram_dq_oe;
                wbo_log[c]  = sel_z ? z_wb_out          : a_wb_out;
            end
            if (f) n_fz++;
            if (!wen) n_wl++;
            @(posedge clk); #1;
            if (!f) begin
                fin = 1'b1;
                break;
            end
        end
        chk({name, "_timeout"}, 32'(fin), 32'd1);
        $display("txn %s: freeze_cycles=%0d we_low_cycles=%0d", name, n_fz, n_wl);
    endtask

    initial begin
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_freeze", 32'(a_freeze), 32'd0);
        chk("rst_we_n",   32'(a_bus.sram_we_n), 32'd1);
        chk("rst_oe",     32'(a_bus.sram_dq_oe), 32'd0);
        chk("rst_addr",   32'(a_bus.sram_addr), 32'd0);
        chk("rst_dq",     32'(a_bus.sram_dq_out), 32'd0);
        chk("rst_data",   a_data_out, 32'd0);
        chk("rst_wb",     32'(a_wb_out), 32'd0);
        $display("txn reset: checked idle outputs");
        #2 rst = 1'b1;
        @(posedge clk); #1;

        // Non-memory ALU op passes straight through.
        set_in(1'b0, 1'b1, 1'b0, 1'b0, 32'd7, 32'd0, 4'd3);
        #1;
        chk("alu_hz_wb",   32'(a_wb_hz), 32'd1);
        chk("alu_hz_dest", 32'(a_dest_hz), 32'd3);
        run_cmd("alu_op", 1'b0, fz, wl);
        chk("alu_freeze", 32'(fz), 32'd0);
        chk("alu_res",    a_alu_out, 32'd7);
        chk("alu_wb",     32'(a_wb_out), 32'd1);
        chk("alu_dest",   32'(a_dest_out), 32'd3);

        // Read word index 2 -> halves at 4 and 5.
        set_in(1'b0, 1'b1, 1'b1, 1'b0, 32'd1032, 32'd0, 4'd5);
        #1 chk("rd_hz_r", 32'(a_r_hz), 32'd1);
        run_cmd("read_1032", 1'b0, fz, wl);
        chk("rd_freeze", 32'(fz), 32'd5);
        chk("rd_we_low", 32'(wl), 32'd0);
        for (int c = 0; c < 6; c++)
            chk($sformatf("rd_addr%0d", c), 32'(addr_log[c]),
                (c == 0 || c == 5) ? 32'd0 : ((c < 3) ? 32'd4 : 32'd5));
        chk("rd_wb_bubble1", 32'(wbo_log[1]), 32'd0);
        chk("rd_wb_bubble5", 32'(wbo_log[5]), 32'd0);
        chk("rd_data",  a_data_out, 32'hDEADBEEF);
        chk("rd_wb",    32'(a_wb_out), 32'd1);
        chk("rd_mr",    32'(a_r_out), 32'd1);
        chk("rd_alu",   a_alu_out, 32'd1032);
        chk("rd_dest",  32'(a_dest_out), 32'd5);

        // Write to word index 0.
        set_in(1'b0, 1'b0, 1'b0, 1'b1, 32'd1024, 32'h12345678, 4'd1);
        run_cmd("write_1024", 1'b0, fz, wl);
        chk("wr_freeze", 32'(fz), 32'd5);
        chk("wr_we_low", 32'(wl), 32'd4);
        chk("wr_addr_lo", 32'(addr_log[1]), 32'd0);
        chk("wr_dq_lo",   32'(dq_log[1]), 32'h5678);
        chk("wr_oe_lo",   32'(oe_log[2]), 32'd1);
        chk("wr_addr_hi", 32'(addr_log[3]), 32'd1);
        chk("wr_dq_hi",   32'(dq_log[3]), 32'h1234);
        chk("wr_mem0",    32'(sram_mem[0]), 32'h5678);
        chk("wr_mem1",    32'(sram_mem[1]), 32'h1234);
        chk("wr_wb",      32'(a_wb_out), 32'd0);

        // Back-to-back: read word index 3, then immediately write word index 4.
        set_in(1'b0, 1'b1, 1'b1, 1'b0, 32'd1036, 32'd0, 4'd6);
        run_cmd("b2b_read", 1'b0, fz, wl);
        chk("b2b_rd_freeze", 32'(fz), 32'd5);
        chk("b2b_rd_data",   a_data_out, 32'h22221111);
        set_in(1'b0, 1'b0, 1'b0, 1'b1, 32'd1040, 32'hAAAA5555, 4'd7);
        run_cmd("b2b_write", 1'b0, fz, wl);
        chk("b2b_wr_freeze", 32'(fz), 32'd5);
        chk("b2b_wr_we_low", 32'(wl), 32'd4);
        chk("b2b_wr_idle",   32'(addr_log[0]), 32'd0);
        chk("b2b_wr_addr",   32'(addr_log[1]), 32'd8);
        chk("b2b_mem8",      32'(sram_mem[8]), 32'h5555);
        chk("b2b_mem9",      32'(sram_mem[9]), 32'hAAAA);
        chk("b2b_data_hold", a_data_out, 32'h22221111);

        // Read and write both set on the zero-wait instance: the read must win.
        set_in(1'b1, 1'b1, 1'b1, 1'b1, 32'd1028, 32'hFFFFFFFF, 4'd2);
        run_cmd("rw_both_w0", 1'b1, fz, wl);
        chk("rw_freeze", 32'(fz), 32'd3);
        chk("rw_we_low", 32'(wl), 32'd0);
        chk("rw_data",   z_data_out, 32'h00A500C3);
        chk("rw_mr",     32'(z_r_out), 32'd1);
        chk("rw_mem2",   32'(sram_mem[2]), 32'h00C3);

        // Reset in the middle of the LOW phase of a write.
        set_in(1'b0, 1'b0, 1'b0, 1'b1, 32'd1024, 32'hCAFEF00D, 4'd0);
        #1 chk("mid_freeze", 32'(a_freeze), 32'd1);
        @(posedge clk); #1;
        chk("mid_we_low", 32'(a_bus.sram_we_n), 32'd0);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_we_n", 32'(a_bus.sram_we_n), 32'd1);
        chk("mid_rst_oe",   32'(a_bus.sram_dq_oe), 32'd0);
        chk("mid_rst_addr", 32'(a_bus.sram_addr), 32'd0);
        chk("mid_rst_data", a_data_out, 32'd0);
        chk("mid_rst_wb",   32'(a_wb_out), 32'd0);
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        #2 rst = 1'b1;
        wl = 0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            if (!a_bus.sram_we_n) wl++;
        end
        chk("post_rst_we_low", 32'(wl), 32'd0);
        chk("post_rst_mem0",   32'(sram_mem[0]), 32'h5678);
        $display("txn reset_mid_write: strobe checked after release");
        set_in(1'b0, 1'b1, 1'b1, 1'b0, 32'd1032, 32'd0, 4'd9);
        run_cmd("post_rst_read", 1'b0, fz, wl);
        chk("post_rst_freeze", 32'(fz), 32'd5);
        chk("post_rst_data",   a_data_out, 32'hDEADBEEF);

        set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", err_cnt);
        $fatal(1);
    end

endmodule

// File: doc/mem_stage_sram.md
MEM_STAGE_SRAM -- requirements
Module: mem_stage_sram

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 1, extra cycles each SRAM half-access is held (legal range 0..15).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have inputs wb_en_in, mem_r_en_in, mem_w_en_in (1 each): control bits from the EXE/MEM register.
REQ-005 SHALL have inputs alu_res_in (32, byte address or ALU result), val_Rm_in (32, store data) and dest_in (4, destination register).
REQ-006 SHALL have output freeze  1  stall request to all upstream pipeline registers.
REQ-007 SHALL have outputs wb_en_hazard_out (1), mem_r_en_hazard_out (1) and dest_hazard_out (4): combinational copies of wb_en_in, mem_r_en_in and dest_in, for the hazard unit.
REQ-008 SHALL have SRAM outputs sram_addr (18), sram_dq_out (16), sram_dq_oe (1) and sram_we_n (1, active-low), plus SRAM input sram_dq_in (16).
REQ-009 SHALL have MEM/WB outputs wb_en_out (1), mem_r_en_out (1), alu_res_out (32), mem_data_out (32) and dest_out (4).

Function
REQ-010 SHALL treat mem_en = mem_r_en_in | mem_w_en_in as a memory command; if both bits are set, the command SHALL be a read and the write SHALL be suppressed.
REQ-011 SHALL compute the word index as bits [18:2] of (alu_res_in - 1024), mod 2^32; sram_addr SHALL be {index[16:0], 0} in the LOW phase and {index[16:0], 1} in the HIGH phase.
REQ-012 SHALL implement an FSM with states IDLE, LOW, HIGH and DONE.
REQ-013 IDLE SHALL go to LOW when mem_en=1 and SHALL stay in IDLE otherwise.
REQ-014 LOW and HIGH SHALL each last WAIT_CYCLES+1 cycles, timed by a 4-bit counter that clears on every phase entry; LOW SHALL go to HIGH, and HIGH SHALL go to DONE.
REQ-015 DONE SHALL last exactly 1 cycle and then go to IDLE.
REQ-016 ready SHALL be 1 in IDLE and DONE and 0 in LOW and HIGH; freeze SHALL equal mem_en & ~ready (combinational); IDLE with mem_en=1 SHALL also assert freeze.
REQ-017 In IDLE and DONE, sram_dq_oe SHALL be 0 and sram_we_n SHALL be 1.
REQ-018 A write SHALL set sram_dq_oe=1 and sram_we_n=0 in every cycle of LOW and HIGH, driving val_Rm_in[15:0] in LOW and val_Rm_in[31:16] in HIGH.
REQ-019 A read SHALL keep sram_we_n=1 and sram_dq_oe=0, capturing sram_dq_in into rdbuf[15:0] on the last LOW cycle and into rdbuf[31:16] on the last HIGH cycle.
REQ-020 The MEM/WB register SHALL load when ready=1: wb_en_out<=wb_en_in, mem_r_en_out<=mem_r_en_in, alu_res_out<=alu_res_in, dest_out<=dest_in.
REQ-021 mem_data_out SHALL load rdbuf in DONE and SHALL hold its value in IDLE.
REQ-022 When ready=0, the MEM/WB register SHALL load a bubble (wb_en_out=0, mem_r_en_out=0) while its other fields hold.
REQ-023 Read latency SHALL be 2*(WAIT_CYCLES+1)+1 cycles from command arrival to MEM/WB load; freeze SHALL be high for 2*(WAIT_CYCLES+1)+1 cycles (IDLE cycle plus both phases), i.e. 5 cycles at WAIT_CYCLES=1.
REQ-024 Inputs SHALL be assumed stable while freeze=1; the FSM SHALL NOT re-trigger in DONE, and a back-to-back command SHALL start from IDLE on the following cycle.

Reset
REQ-025 rst=0 SHALL force, asynchronously: state=IDLE, counter=0, rdbuf=0 and all MEM/WB outputs =0.
REQ-026 During reset the SRAM outputs SHALL be sram_we_n=1, sram_dq_oe=0, sram_addr=0 and sram_dq_out=0.
REQ-027 A reset asserted mid-access SHALL abort the access with no further SRAM write strobe after rst deasserts.

Structure
REQ-028 Package mem_pkg SHALL hold the FSM state enum, BASE_ADDR=1024, SRAM_ADDR_W=18 and SRAM_DATA_W=16.
REQ-029 The FSM, counter, rdbuf and SRAM pins SHALL live in sub-module sram_controller; the top level SHALL contain only the MEM/WB register and the hazard pass-through.

Verification
REQ-030 Reset mid-write: assert rst=0 during LOW -> sram_we_n=1 immediately; after release, state=IDLE and the outputs carry no stale data.
REQ-031 Read at WAIT_CYCLES=1, alu_res_in=1032, SRAM returning 0xBEEF then 0xDEAD -> sram_addr=4 then 5; freeze high 5 cycles; mem_data_out=0xDEADBEEF; wb_en_out=0 until the load.
REQ-032 Write of val_Rm_in=0x12345678 at alu_res_in=1024 -> sram_dq_out=0x5678 at address 0, then 0x1234 at address 1; sram_we_n low 4 cycles.
REQ-033 Non-memory ALU op (wb_en_in=1, alu_res_in=7) -> freeze=0; alu_res_out=7 and wb_en_out=1 one cycle later.
REQ-034 Both r and w set, WAIT_CYCLES=0 -> read performed, sram_we_n never low, freeze high 3 cycles.
REQ-035 Back-to-back read then write -> two complete FSM passes with an IDLE cycle between them; no missed command.
